// File: rtl/clk_div_mon_pkg.sv
// ============================================================================
// Module   : clk_div_mon_pkg
// Brief    : Shared types and helpers for the divided-clock monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_mon_pkg;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        MEAS = 1'b1
    } mon_state_t;

    // Wide all-ones pattern; callers slice it down to their counter width.
    localparam logic [31:0] SAT_ALL_ONES = 32'hFFFF_FFFF;

    function automatic int unsigned exp_period(input int unsigned div);
        return 2 * div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dual_edge_sampler.sv
// ============================================================================
// Module   : dual_edge_sampler
// Brief    : Captures a signal on the falling clk edge and presents it with the
//            live value, giving an ordered pair of half-cycle samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_edge_sampler (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic first,
    output logic second
);

    logic s_n;

    always_ff @(negedge clk) begin
        if (reset) begin
            s_n <= 1'b0;
        end else begin
            s_n <= din;
        end
    end

    assign first  = s_n;
    assign second = din;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module   : clk_div_monitor
// Brief    : Measures period/high time of a divided clock in clk half-cycles,
//            flags ratio/duty errors, tracks lock and stuck conditions.
//            Define CLK_DIV_MON_DUTY_TOL_EN for a +/-1 half-cycle duty window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned DIV_EXP  = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period_hc,
    output logic [CNT_W-1:0] high_hc,
    output logic             meas_valid,
    output logic             ratio_ok,
    output logic             duty_ok,
    output logic             locked,
    output logic             stuck
);

    localparam int unsigned      LOCK_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] SAT      = SAT_ALL_ONES[CNT_W-1:0];
    localparam logic [CNT_W:0]   EXP_P    = (CNT_W+1)'(exp_period(DIV_EXP));
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

    logic smp_a;
    logic smp_b;

    dual_edge_sampler u_sampler (
        .clk    (clk),
        .reset  (reset),
        .din    (div_clk),
        .first  (smp_a),
        .second (smp_b)
    );

    mon_state_t        state_q, state_d;
    logic              prev_q;
    logic [CNT_W-1:0]  hi_cnt, lo_cnt, hi_d, lo_d;
    logic [LOCK_W-1:0] lock_cnt, lock_d;
    logic [CNT_W-1:0]  hi_a, lo_a, hi_b, lo_b;
    logic [CNT_W-1:0]  meas_hi, meas_lo, meas_period;
    logic [CNT_W:0]    meas_sum, twice_hi, per_ext, duty_diff;
    logic              rise_a, rise_b, any_rise, do_meas, sat_hit;
    logic              ratio_d, duty_d, stuck_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
        if (en && (v != SAT)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // The previous sample chains across the pair: prev_q -> smp_a -> smp_b.
    assign rise_a   = smp_a & ~prev_q;
    assign rise_b   = smp_b & ~smp_a;
    assign any_rise = rise_a | rise_b;
    assign do_meas  = any_rise && (state_q == MEAS);

    always_comb begin
        hi_a = sat_inc(hi_cnt, smp_a);
        lo_a = sat_inc(lo_cnt, ~smp_a);
        hi_b = sat_inc(hi_a, smp_b);
        lo_b = sat_inc(lo_a, ~smp_b);

        // A rise on the first sample closes the period before that sample.
        meas_hi = rise_a ? hi_cnt : hi_a;
        meas_lo = rise_a ? lo_cnt : lo_a;

        if (rise_a) begin
            hi_d = smp_b ? CNT_W'(2) : CNT_W'(1);
            lo_d = smp_b ? '0 : CNT_W'(1);
        end else if (rise_b) begin
            hi_d = CNT_W'(1);
            lo_d = '0;
        end else begin
            hi_d = hi_b;
            lo_d = lo_b;
        end

        sat_hit = !any_rise && ((hi_d == SAT) || (lo_d == SAT));

        meas_sum    = {1'b0, meas_hi} + {1'b0, meas_lo};
        meas_period = (meas_sum > {1'b0, SAT}) ? SAT : meas_sum[CNT_W-1:0];
        per_ext     = {1'b0, meas_period};
        twice_hi    = {meas_hi, 1'b0};
        duty_diff   = (twice_hi >= per_ext) ? (twice_hi - per_ext)
                                            : (per_ext - twice_hi);
        ratio_d     = (per_ext == EXP_P);
`ifdef CLK_DIV_MON_DUTY_TOL_EN
        duty_d      = (duty_diff <= (CNT_W+1)'(2));
`else
        duty_d      = (duty_diff == '0);
`endif

        lock_d = lock_cnt;
        if (sat_hit) begin
            lock_d = '0;
        end else if (do_meas) begin
            if (ratio_d && duty_d) begin
                lock_d = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
            end else begin
                lock_d = '0;
            end
        end

        stuck_d = stuck;
        if (any_rise) begin
            stuck_d = 1'b0;
        end else if (sat_hit) begin
            stuck_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sat_hit) begin
            state_d = SEEK;
        end else if (any_rise) begin
            state_d = MEAS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= 1'b1;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            lock_cnt   <= '0;
            period_hc  <= '0;
            high_hc    <= '0;
            meas_valid <= 1'b0;
            ratio_ok   <= 1'b0;
            duty_ok    <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            prev_q     <= smp_b;
            hi_cnt     <= hi_d;
            lo_cnt     <= lo_d;
            lock_cnt   <= lock_d;
            locked     <= (lock_d == LOCK_MAX);
            stuck      <= stuck_d;
            meas_valid <= do_meas;
            if (do_meas) begin
                period_hc <= meas_period;
                high_hc   <= meas_hi;
                ratio_ok  <= ratio_d;
                duty_ok   <= duty_d;
            end
        end
    end

endmodule

`default_nettype wire
